// File: rtl/modelado_feeder_pkg.sv
// Shared types for the Modelado datapath and its operand feeder.
package modelado_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      APPLY,
      WRITE,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/modelado_feeder_if.sv
// Bus bundle between the feeder, its sample/result memories and Modelado.
interface modelado_feeder_if
   import modelado_pkg::*;
#(
   parameter int ADDR_W = 10
);

   logic              start;
   logic [ADDR_W:0]   count;
   word_t             y_cfg;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   word_t             rd_data;
   word_t             x;
   word_t             y;
   word_t             result;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   word_t             wr_data;
   logic              wr_ready;
   logic              busy;
   logic              done;

   modport master (
      input  start, count, y_cfg, rd_data, result, wr_ready,
      output rd_en, rd_addr, x, y, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, count, y_cfg, rd_data, result, wr_ready,
      input  rd_en, rd_addr, x, y, wr_en, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/modelado_feeder_settle_counter.sv
// Fixed-latency down counter: load to MAX, count down, flag the final cycle.
module settle_counter #(
   parameter int MAX = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic last
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [W-1:0] value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= W'(MAX);
      end else if (dec && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   assign last = (value == W'(1));

endmodule

// File: rtl/modelado_feeder.sv
// Operand sequencer for Modelado: fetches x words, holds x/y for LAT cycles,
// then writes the captured result back with ready backpressure.
module modelado_feeder
   import modelado_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   modelado_feeder_if.master bus
);

   feeder_state_t     state;
   feeder_state_t     state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   count_q;
   word_t             x_q;
   word_t             y_q;
   word_t             wr_data_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              settle_last;
   logic              is_last_word;
   logic              rd_en_c;
   logic              wr_en_c;
   logic              busy_c;
   logic              done_c;

   settle_counter #(
      .MAX (LAT)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (state == WAIT_RD),
      .dec   (state == APPLY),
      .last  (settle_last)
   );

   // count is one bit wider than idx so a full 2^ADDR_W batch compares cleanly
   assign is_last_word = (({1'b0, idx} + (ADDR_W+1)'(1)) == count_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en_c   = 1'b0;
      wr_en_c   = 1'b0;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               state_nxt = (bus.count == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            rd_en_c   = 1'b1;
            state_nxt = WAIT_RD;
         end
         WAIT_RD: begin
            state_nxt = APPLY;
         end
         APPLY: begin
            if (settle_last) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            wr_en_c = 1'b1;
            if (bus.wr_ready) begin
               state_nxt = is_last_word ? DONE : FETCH;
            end
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand and write-channel registers; x/y keep their value between batches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         count_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
      end else begin
         if ((state == IDLE) && bus.start) begin
            idx     <= '0;
            count_q <= bus.count;
            y_q     <= bus.y_cfg;
         end
         if (state == WAIT_RD) begin
            x_q <= bus.rd_data;
         end
         if ((state == APPLY) && settle_last) begin
            wr_data_q <= bus.result;
            wr_addr_q <= idx;
         end
         if ((state == WRITE) && bus.wr_ready && !is_last_word) begin
            idx <= idx + (ADDR_W)'(1);
         end
      end
   end

   assign bus.rd_en   = rd_en_c;
   assign bus.rd_addr = idx;
   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.wr_en   = wr_en_c;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;

endmodule

// File: tb/tb_modelado_feeder.sv
// Directed bench for modelado_feeder: LAT=1 instance for batch behaviour,
// LAT=4 instance for the full 1024-word range.
module tb_modelado_feeder;
   import modelado_pkg::*;

   typedef struct {
      logic [9:0] addr;
      word_t      data;
      int         age;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   modelado_feeder_if #(.ADDR_W(10)) bus1 ();
   modelado_feeder_if #(.ADDR_W(10)) bus4 ();

   modelado_feeder #(.ADDR_W(10), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   modelado_feeder #(.ADDR_W(10), .LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   word_t mem1 [1024];
   word_t mem4 [1024];
   wr_t   q1 [$];
   wr_t   q4 [$];
   wr_t   obs1 [$];
   wr_t   obs4 [$];

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    busy1 = 0, rd1 = 0, wr1 = 0, done1 = 0, doneCyc1 = 0;
   int    busy4 = 0, rd4 = 0, wr4 = 0, done4 = 0, doneCyc4 = 0;
   int    xAge4 = 0;
   word_t xPrev4 = '0;
   int    lastAddr4 = 0;
   int    baseDone, baseBusy, baseRd, baseWr, startCyc, rdHold;
   bit    seen;

   // Behavioural stand-in for the Modelado datapath
   function automatic word_t modelado_fn(word_t a, word_t b);
      return (a * b) ^ {b[15:0], a[31:16]};
   endfunction

   assign bus1.result = modelado_fn(bus1.x, bus1.y);
   assign bus4.result = modelado_fn(bus4.x, bus4.y);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= mem1[bus1.rd_addr];
   always @(posedge clk) if (bus4.rd_en) bus4.rd_data <= mem4[bus4.rd_addr];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.busy) busy1 <= busy1 + 1;
         if (bus1.rd_en) rd1 <= rd1 + 1;
         if (bus1.done) begin
            done1    <= done1 + 1;
            doneCyc1 <= cyc;
         end
         if (bus1.wr_en && bus1.wr_ready) begin
            wr1 <= wr1 + 1;
            obs1.push_back('{addr: bus1.wr_addr, data: bus1.wr_data, age: 0});
         end
      end
   end

   // x age = cycles x has held its current value, including this one
   always @(negedge clk) begin
      xPrev4 <= bus4.x;
      xAge4  <= (bus4.x !== xPrev4) ? 1 : xAge4 + 1;
      if (rst_n) begin
         if (bus4.busy) busy4 <= busy4 + 1;
         if (bus4.rd_en) rd4 <= rd4 + 1;
         if (bus4.done) begin
            done4    <= done4 + 1;
            doneCyc4 <= cyc;
         end
         if (bus4.wr_en && bus4.wr_ready) begin
            wr4       <= wr4 + 1;
            lastAddr4 <= int'(bus4.wr_addr);
            obs4.push_back('{addr: bus4.wr_addr, data: bus4.wr_data,
                             age: (bus4.x !== xPrev4) ? 1 : xAge4 + 1});
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drain();
      wr_t o;
      wr_t e;
      while (obs1.size() > 0) begin
         o = obs1.pop_front();
         checkOutput("write1_expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("wr_addr1", o.addr, e.addr);
            checkOutput("wr_data1", o.data, e.data);
         end
      end
      while (obs4.size() > 0) begin
         o = obs4.pop_front();
         checkOutput("write4_expected", q4.size() > 0, 1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput("wr_addr4", o.addr, e.addr);
            checkOutput("wr_data4", o.data, e.data);
            checkOutput("x_age4", o.age, 5);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic applyStimulus(input bit sel4, input int cnt, input word_t yv,
                                input bit accepted);
      if (accepted) begin
         for (int i = 0; i < cnt; i++) begin
            if (sel4) q4.push_back('{addr: 10'(i), data: modelado_fn(mem4[i], yv), age: 0});
            else      q1.push_back('{addr: 10'(i), data: modelado_fn(mem1[i], yv), age: 0});
         end
         baseDone = sel4 ? done4 : done1;
         baseBusy = sel4 ? busy4 : busy1;
         baseRd   = sel4 ? rd4 : rd1;
         baseWr   = sel4 ? wr4 : wr1;
         startCyc = cyc;
      end
      if (sel4) begin
         bus4.start = 1'b1; bus4.count = 11'(cnt); bus4.y_cfg = yv;
      end else begin
         bus1.start = 1'b1; bus1.count = 11'(cnt); bus1.y_cfg = yv;
      end
      tick();
      bus1.start = 1'b0;
      bus4.start = 1'b0;
   endtask

   task automatic waitDone(input bit sel4, input int budget);
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         seen = ((sel4 ? done4 : done1) > baseDone);
      end
      checkOutput("done_seen", seen, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctrl"}, {bus1.rd_en, bus1.wr_en, bus1.busy, bus1.done}, 0);
      checkOutput({tag, "_x"}, bus1.x, 0);
      checkOutput({tag, "_y"}, bus1.y, 0);
      checkOutput({tag, "_wr_data"}, bus1.wr_data, 0);
      checkOutput({tag, "_addrs"}, {bus1.rd_addr, bus1.wr_addr}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      bus1.start = 1'b0; bus1.count = '0; bus1.y_cfg = '0; bus1.wr_ready = 1'b1;
      bus4.start = 1'b0; bus4.count = '0; bus4.y_cfg = '0; bus4.wr_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         mem1[i] = '0;
         mem4[i] = 32'h1000_0000 + 32'(i);
      end
      tick();
      tick();

      $display("[TB] reset state");
      checkAllZero("reset");
      rst_n = 1'b1;
      tick();

      $display("[TB] basic batch");
      for (int i = 0; i < 4; i++) mem1[i] = 32'(i + 1);
      applyStimulus(0, 4, 32'h0000_0003, 1);
      waitDone(0, 100);
      checkOutput("basic_latency", doneCyc1 - startCyc + 1, 18);
      checkOutput("basic_busy", busy1 - baseBusy, 17);
      checkOutput("basic_reads", rd1 - baseRd, 4);
      checkOutput("basic_writes", wr1 - baseWr, 4);
      checkOutput("basic_done_count", done1 - baseDone, 1);
      checkOutput("basic_queue_empty", q1.size(), 0);

      $display("[TB] backpressure");
      mem1[0] = 32'd10;
      mem1[1] = 32'd20;
      bus1.wr_ready = 1'b0;
      applyStimulus(0, 2, 32'd5, 1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (bus1.wr_en) seen = 1'b1;
         else tick();
      end
      checkOutput("bp_wr_en_seen", seen, 1);
      rdHold = rd1;
      for (int j = 0; j < 5; j++) begin
         checkOutput("bp_wr_en_held", bus1.wr_en, 1);
         checkOutput("bp_wr_addr_held", bus1.wr_addr, 0);
         checkOutput("bp_wr_data_held", bus1.wr_data, modelado_fn(32'd10, 32'd5));
         tick();
      end
      checkOutput("bp_no_read_while_stalled", rd1 - rdHold, 0);
      bus1.wr_ready = 1'b1;
      waitDone(0, 100);
      checkOutput("bp_latency", doneCyc1 - startCyc + 1, 15);
      checkOutput("bp_writes", wr1 - baseWr, 2);

      $display("[TB] zero count");
      applyStimulus(0, 0, 32'h0000_0077, 1);
      waitDone(0, 20);
      checkOutput("zero_latency", doneCyc1 - startCyc + 1, 2);
      checkOutput("zero_busy", busy1 - baseBusy, 1);
      checkOutput("zero_reads", rd1 - baseRd, 0);
      checkOutput("zero_writes", wr1 - baseWr, 0);
      checkOutput("zero_y_latched", bus1.y, 32'h0000_0077);

      $display("[TB] start while busy");
      for (int i = 0; i < 8; i++) mem1[i] = 32'h0000_0100 + 32'(i);
      applyStimulus(0, 3, 32'd9, 1);
      tick();
      tick();
      tick();
      applyStimulus(0, 7, 32'hDEAD_BEEF, 0);
      waitDone(0, 100);
      repeat (30) tick();
      checkOutput("busy_start_writes", wr1 - baseWr, 3);
      checkOutput("busy_start_done_count", done1 - baseDone, 1);
      checkOutput("busy_start_y", bus1.y, 32'd9);
      checkOutput("busy_start_queue_empty", q1.size(), 0);

      $display("[TB] reset mid-batch");
      for (int i = 0; i < 4; i++) mem1[i] = 32'h0000_0040 + 32'(i);
      applyStimulus(0, 4, 32'd2, 1);
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         if (bus1.rd_en && (bus1.rd_addr == 10'd2)) seen = 1'b1;
         else tick();
      end
      checkOutput("reset_fetch2_seen", seen, 1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      checkOutput("midreset_partial_writes", wr1 - baseWr, 2);
      q1.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("midreset_no_done", done1 - baseDone, 0);
      mem1[0] = 32'd100;
      mem1[1] = 32'd200;
      applyStimulus(0, 2, 32'd3, 1);
      waitDone(0, 50);
      checkOutput("restart_writes", wr1 - baseWr, 2);
      checkOutput("restart_queue_empty", q1.size(), 0);

      $display("[TB] LAT=4 full range");
      applyStimulus(1, 1024, 32'h0000_0011, 1);
      waitDone(1, 8000);
      checkOutput("full_latency", doneCyc4 - startCyc + 1, 1024 * 7 + 2);
      checkOutput("full_writes", wr4 - baseWr, 1024);
      checkOutput("full_reads", rd4 - baseRd, 1024);
      checkOutput("full_last_addr", lastAddr4, 1023);
      checkOutput("full_queue_empty", q4.size(), 0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
